crypto_hft_asic_top: RTL and testbench

CRYPTO_HFT_ASIC_TOP -- requirements
Module: crypto_hft_asic_top

---
 rtl/crypto_hft_pkg.sv | 33 +++
 rtl/crypto_hft_strategy_engine.sv | 22 ++
 rtl/crypto_hft_asic_top.sv | 122 ++++++++++++
 tb/tb_crypto_hft_asic_top.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/crypto_hft_pkg.sv
// Shared types and order-word layout for the crypto HFT datapath.
package crypto_hft_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RX1    = 2'd1,
    DECIDE = 2'd2
  } hft_state_e;

  localparam logic [7:0] ORDER_OPCODE = 8'hA5;

  localparam int OP_MSB    = 63;
  localparam int OP_LSB    = 56;
  localparam int SIDE_BIT  = 48;
  localparam int QTY_MSB   = 47;
  localparam int QTY_LSB   = 32;
  localparam int PRICE_MSB = 31;
  localparam int PRICE_LSB = 0;

  // Assemble an order word; bits [55:49] stay zero.
  function automatic logic [63:0] pack_order(input logic        side,
                                             input logic [15:0] qty,
                                             input logic [31:0] price);
    logic [63:0] w;
    w                      = '0;
    w[OP_MSB:OP_LSB]       = ORDER_OPCODE;
    w[SIDE_BIT]            = side;
    w[QTY_MSB:QTY_LSB]     = qty;
    w[PRICE_MSB:PRICE_LSB] = price;
    return w;
  endfunction

endpackage

// File: rtl/crypto_hft_strategy_engine.sv
// Combinational spread decision: trigger, side and the lower of the two prices.
module hft_strategy_engine #(
  parameter logic [31:0] SPREAD_THRESH = 32'h0000_1000
) (
  input  logic [31:0] price_a,
  input  logic [31:0] price_b,
  output logic        trigger,
  output logic        side,
  output logic [31:0] min_price
);

  logic [31:0] spread;

  // Unsigned absolute difference; BUY when price_b is the cheaper side.
  always_comb begin
    side      = (price_b < price_a);
    spread    = side ? (price_a - price_b) : (price_b - price_a);
    trigger   = (spread >= SPREAD_THRESH);
    min_price = side ? price_b : price_a;
  end

endmodule

// File: rtl/crypto_hft_asic_top.sv
// Two-beat market-data receiver, spread strategy and order generator.
// Optional macro LATENCY_STATS_EN enables the network/total latency counters.
module crypto_hft_asic_top
  import crypto_hft_pkg::*;
#(
  parameter logic [31:0] SPREAD_THRESH = 32'h0000_1000,
  parameter logic [15:0] ORDER_QTY     = 16'd100,
  parameter int unsigned RX_TIMEOUT    = 255
) (
  input  logic        clk_core,
  input  logic        rst,
  input  logic [63:0] net_rx_data,
  input  logic        net_rx_valid,
  output logic [63:0] net_tx_data,
  output logic        net_tx_valid,
  output logic [31:0] network_latency,
  output logic [31:0] total_latency,
  output logic [31:0] trades_executed,
  output logic        system_active
);

  localparam logic [31:0] TO_LAST = 32'(RX_TIMEOUT - 1);

  hft_state_e  state, state_nxt;
  logic        beat0_acc, beat1_acc;
  logic [31:0] to_cnt;
  logic [31:0] price_a_p0, price_b_p0;
  logic        trigger, side;
  logic [31:0] min_price;
  logic        order_fire;
  logic        unused_hdr;

  // Header halves of each beat carry nothing the strategy uses.
  assign unused_hdr = ^net_rx_data[63:32];

  assign beat0_acc     = (state == IDLE) && net_rx_valid;
  assign beat1_acc     = (state == RX1) && net_rx_valid;
  assign order_fire    = (state == DECIDE) && trigger;
  assign system_active = (state != IDLE);

  // State register.
  always_ff @(posedge clk_core) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: beat0 -> RX1 -> DECIDE -> IDLE, with a second-beat timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (net_rx_valid) state_nxt = RX1;
      RX1: begin
        if (net_rx_valid)           state_nxt = DECIDE;
        else if (to_cnt == TO_LAST) state_nxt = IDLE;
      end
      DECIDE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Idle cycles spent waiting for beat1.
  always_ff @(posedge clk_core) begin
    if (rst)                                to_cnt <= '0;
    else if (beat0_acc)                     to_cnt <= '0;
    else if ((state == RX1) && !net_rx_valid) to_cnt <= to_cnt + 32'd1;
  end

  // Stage p0: capture the two prices of the packet.
  always_ff @(posedge clk_core) begin
    if (beat0_acc) price_a_p0 <= net_rx_data[31:0];
    if (beat1_acc) price_b_p0 <= net_rx_data[31:0];
  end

  hft_strategy_engine #(
    .SPREAD_THRESH (SPREAD_THRESH)
  ) u_engine (
    .price_a   (price_a_p0),
    .price_b   (price_b_p0),
    .trigger   (trigger),
    .side      (side),
    .min_price (min_price)
  );

  // Stage p1: registered order output, held until the next beat0 is accepted.
  always_ff @(posedge clk_core) begin
    if (rst) begin
      net_tx_valid    <= 1'b0;
      net_tx_data     <= '0;
      trades_executed <= '0;
    end else begin
      if (beat0_acc) net_tx_valid <= 1'b0;
      if (order_fire) begin
        net_tx_valid    <= 1'b1;
        net_tx_data     <= pack_order(side, ORDER_QTY, min_price);
        trades_executed <= trades_executed + 32'd1;
      end
    end
  end

`ifdef LATENCY_STATS_EN
  logic [31:0] lat_cnt;

  // Latency counter is 0 in the beat0 cycle; total_latency takes the value
  // the counter will hold in the cycle net_tx_valid is first high.
  always_ff @(posedge clk_core) begin
    if (rst) begin
      lat_cnt         <= '0;
      network_latency <= '0;
      total_latency   <= '0;
    end else begin
      if (beat0_acc)           lat_cnt <= 32'd1;
      else if (state != IDLE)  lat_cnt <= lat_cnt + 32'd1;
      if (beat1_acc)  network_latency <= lat_cnt;
      if (order_fire) total_latency   <= lat_cnt + 32'd1;
    end
  end
`else
  assign network_latency = '0;
  assign total_latency   = '0;
`endif

endmodule

// File: tb/tb_crypto_hft_asic_top.sv
// Directed self-checking bench for crypto_hft_asic_top.
module tb_crypto_hft_asic_top;

  logic        clk_core;
  logic        rst;
  logic [63:0] net_rx_data;
  logic        net_rx_valid;
  logic [63:0] net_tx_data;
  logic        net_tx_valid;
  logic [31:0] network_latency;
  logic [31:0] total_latency;
  logic [31:0] trades_executed;
  logic        system_active;

  int errors = 0;
  int checks = 0;

`ifdef LATENCY_STATS_EN
  localparam bit LAT_ON = 1'b1;
`else
  localparam bit LAT_ON = 1'b0;
`endif

  crypto_hft_asic_top dut (
    .clk_core        (clk_core),
    .rst             (rst),
    .net_rx_data     (net_rx_data),
    .net_rx_valid    (net_rx_valid),
    .net_tx_data     (net_tx_data),
    .net_tx_valid    (net_tx_valid),
    .network_latency (network_latency),
    .total_latency   (total_latency),
    .trades_executed (trades_executed),
    .system_active   (system_active)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  function automatic logic [31:0] lat(input logic [31:0] v);
    return LAT_ON ? v : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one valid beat for exactly one rising edge, then sample 1ns later.
  task automatic beat(input logic [63:0] d);
    net_rx_valid = 1'b1;
    net_rx_data  = d;
    @(posedge clk_core);
    #1;
    net_rx_valid = 1'b0;
    net_rx_data  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_core);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk_core);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    net_rx_valid = 1'b0;
    net_rx_data  = '0;
    do_reset();

    // Reset state
    check("rst_tx_valid", 64'(net_tx_valid), 64'd0);
    check("rst_tx_data", net_tx_data, 64'd0);
    check("rst_trades", 64'(trades_executed), 64'd0);
    check("rst_net_lat", 64'(network_latency), 64'd0);
    check("rst_tot_lat", 64'(total_latency), 64'd0);
    check("rst_active", 64'(system_active), 64'd0);

    // Reset mid-packet: beat0 discarded, no order emerges
    beat(64'h0000_0000_0000_5000);
    check("mid_active_rx1", 64'(system_active), 64'd1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mid_active_after_rst", 64'(system_active), 64'd0);
    beat(64'h0000_0000_0000_1000);
    idle(3);
    check("mid_tx_valid", 64'(net_tx_valid), 64'd0);
    check("mid_tx_data", net_tx_data, 64'd0);
    check("mid_trades", 64'(trades_executed), 64'd0);
    check("mid_net_lat", 64'(network_latency), 64'd0);
    check("mid_tot_lat", 64'(total_latency), 64'd0);
    do_reset();

    // Nominal back-to-back packet, BUY
    beat(64'h1234_5678_A8C0_0000);
    beat(64'h9ABC_DEF0_0A00_0000);
    check("nom_active_decide", 64'(system_active), 64'd1);
    check("nom_tx_valid_pre", 64'(net_tx_valid), 64'd0);
    idle(1);
    check("nom_tx_valid", 64'(net_tx_valid), 64'd1);
    check("nom_tx_data", net_tx_data, 64'hA501_0064_0A00_0000);
    check("nom_trades", 64'(trades_executed), 64'd1);
    check("nom_net_lat", 64'(network_latency), 64'(lat(32'd1)));
    check("nom_tot_lat", 64'(total_latency), 64'(lat(32'd3)));
    check("nom_active_idle", 64'(system_active), 64'd0);
    idle(3);
    check("nom_tx_valid_held", 64'(net_tx_valid), 64'd1);
    check("nom_tx_data_held", net_tx_data, 64'hA501_0064_0A00_0000);

    // Equal prices: no order, beat0 clears the held order valid
    beat(64'h0000_0000_0100_0000);
    check("eq_tx_valid_cleared", 64'(net_tx_valid), 64'd0);
    beat(64'h0000_0000_0100_0000);
    idle(1);
    check("eq_active", 64'(system_active), 64'd0);
    check("eq_tx_valid", 64'(net_tx_valid), 64'd0);
    check("eq_trades", 64'(trades_executed), 64'd1);

    // SELL with a 4-idle-cycle gap
    beat(64'h0000_0000_0000_1000);
    idle(4);
    beat(64'h0000_0000_0000_3000);
    idle(1);
    check("sell_tx_valid", 64'(net_tx_valid), 64'd1);
    check("sell_tx_data", net_tx_data, 64'hA500_0064_0000_1000);
    check("sell_trades", 64'(trades_executed), 64'd2);
    check("sell_net_lat", 64'(network_latency), 64'(lat(32'd5)));
    check("sell_tot_lat", 64'(total_latency), 64'(lat(32'd7)));

    // Timeout: beat0 only, packet dropped after 255 idle cycles
    beat(64'h0000_0000_0000_9000);
    idle(254);
    check("to_active_254", 64'(system_active), 64'd1);
    idle(1);
    check("to_active_255", 64'(system_active), 64'd0);
    check("to_tx_valid", 64'(net_tx_valid), 64'd0);
    check("to_trades", 64'(trades_executed), 64'd2);

    // Spread one below threshold: no order
    beat(64'h0000_0000_0000_2000);
    beat(64'h0000_0000_0000_1001);
    idle(1);
    check("below_tx_valid", 64'(net_tx_valid), 64'd0);
    check("below_trades", 64'(trades_executed), 64'd2);

    // Spread exactly at threshold: order, BUY at 0x1000
    beat(64'h0000_0000_0000_2000);
    beat(64'h0000_0000_0000_1000);
    idle(1);
    check("thr_tx_valid", 64'(net_tx_valid), 64'd1);
    check("thr_tx_data", net_tx_data, 64'hA501_0064_0000_1000);
    check("thr_trades", 64'(trades_executed), 64'd3);
    check("thr_net_lat", 64'(network_latency), 64'(lat(32'd1)));
    check("thr_tot_lat", 64'(total_latency), 64'(lat(32'd3)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
